// File: rtl/ysyx_23060236_wbu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060236_wbu_pkg
// Shared definitions for the write-back unit: FSM state encoding, RV32 load
// funct3 codes and the record of a load that is waiting for its data.
// ---------------------------------------------------------------------------
package ysyx_23060236_wbu_pkg;

   // Write-back FSM states; the encoding is visible to anyone probing the
   // state register, so it is pinned explicitly.
   typedef enum logic [0:0] {
      WBU_IDLE      = 1'b0,
      WBU_WAIT_LOAD = 1'b1
   } wbu_state_e;

   // RV32 load funct3 codes. Any other code is treated as a full-word load.
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // What must be remembered about an accepted load until its data returns.
   // The destination register index is kept separately because its width
   // follows the ADDR_WIDTH parameter of the instantiating module.
   typedef struct packed {
      logic       wen;
      logic [2:0] funct3;
      logic [1:0] addr_lo;
   } load_ctx_t;

endpackage : ysyx_23060236_wbu_pkg

// File: rtl/ysyx_23060236_load_ext.sv
// ---------------------------------------------------------------------------
// ysyx_23060236_load_ext
// Purely combinational load-data formatter. Takes the aligned 32-bit word
// returned by the LSU, picks the byte or halfword selected by the low address
// bits and sign- or zero-extends it according to funct3. Unknown funct3
// codes pass the full word through. Only meaningful for DATA_WIDTH = 32.
// ---------------------------------------------------------------------------
module ysyx_23060236_load_ext
   import ysyx_23060236_wbu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] rdata_i,
   input  logic [2:0]            funct3_i,
   input  logic [1:0]            addr_lo_i,
   output logic [DATA_WIDTH-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Select the addressed byte lane and halfword lane of the returned word.
   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a default
      // first, so no path through the case statements can infer a latch.
      byte_sel = rdata_i[7:0];
      unique case (addr_lo_i)
         2'd0: byte_sel = rdata_i[7:0];
         2'd1: byte_sel = rdata_i[15:8];
         2'd2: byte_sel = rdata_i[23:16];
         2'd3: byte_sel = rdata_i[31:24];
         default: byte_sel = rdata_i[7:0];
      endcase
      half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   // Extend the selected lane to the datapath width according to funct3.
   always_comb begin
      data_o = rdata_i;
      unique case (funct3_i)
         F3_LB:   data_o = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
         F3_LH:   data_o = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
         F3_LBU:  data_o = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
         F3_LHU:  data_o = {{(DATA_WIDTH-16){1'b0}}, half_sel};
         F3_LW:   data_o = rdata_i;
         default: data_o = rdata_i;
      endcase
   end

endmodule : ysyx_23060236_load_ext

// File: rtl/ysyx_23060236_wbu.sv
// ---------------------------------------------------------------------------
// ysyx_23060236_wbu
// Write-back unit in front of the RV32E register file.
//  - Accepts retired instructions from EXU/LSU on a valid/ready handshake.
//  - Non-loads commit the cycle after acceptance (one per cycle).
//  - Loads park in WAIT_LOAD until lsu_rvalid; good data is extended and
//    committed the following cycle, a bus error raises a one-cycle load_err.
//  - All register-file strobes are registered; hz_stall is combinational and
//    covers both a pending load and a write landing in the current cycle.
// Optional build macro YSYX_23060236_WBU_INSTRET_EN adds a 64-bit retired
// instruction counter on output port instret.
// ---------------------------------------------------------------------------
module ysyx_23060236_wbu
   import ysyx_23060236_wbu_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   // upstream instruction handshake
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] in_rd,
   input  logic                  in_wen,
   input  logic                  in_is_load,
   input  logic [2:0]            in_funct3,
   input  logic [1:0]            in_addr_lo,
   input  logic [DATA_WIDTH-1:0] in_result,
   // load data return
   input  logic                  lsu_rvalid,
   input  logic [DATA_WIDTH-1:0] lsu_rdata,
   input  logic                  lsu_rerr,
   // register file write port
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic                  rf_wen,
   output logic                  rf_valid,
   output logic                  load_err,
   // decode hazard query
   input  logic [ADDR_WIDTH-1:0] hz_raddr1,
   input  logic [ADDR_WIDTH-1:0] hz_raddr2,
   output logic                  hz_stall
`ifdef YSYX_23060236_WBU_INSTRET_EN
   ,
   output logic [63:0]           instret
`endif
);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   wbu_state_e            state_q,    state_d;
   logic [ADDR_WIDTH-1:0] ld_rd_q,    ld_rd_d;
   load_ctx_t             ld_ctx_q,   ld_ctx_d;

   logic                  rf_valid_q, rf_valid_d;
   logic                  rf_wen_q,   rf_wen_d;
   logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
   logic                  load_err_q, load_err_d;

   logic [DATA_WIDTH-1:0] ext_data;

   // ------------------------------------------------------------------------
   // Load data formatting, driven from the captured load context
   // ------------------------------------------------------------------------
   ysyx_23060236_load_ext #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_load_ext (
      .rdata_i   (lsu_rdata),
      .funct3_i  (ld_ctx_q.funct3),
      .addr_lo_i (ld_ctx_q.addr_lo),
      .data_o    (ext_data)
   );

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------

   // State register; reset aborts any outstanding load.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!reset) begin
         state_q <= WBU_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a load handshake parks the unit until its data returns;
   // lsu_rvalid in IDLE is a protocol violation and is ignored.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         WBU_IDLE:      if (in_valid && in_is_load) state_d = WBU_WAIT_LOAD;
         WBU_WAIT_LOAD: if (lsu_rvalid)             state_d = WBU_IDLE;
         default:       state_d = WBU_IDLE;
      endcase
   end

   // Outputs: ready strobe, next commit values and load-context capture.
   always_comb begin
      in_ready   = (state_q == WBU_IDLE);
      rf_valid_d = 1'b0;
      rf_wen_d   = 1'b0;
      load_err_d = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      ld_rd_d    = ld_rd_q;
      ld_ctx_d   = ld_ctx_q;

      unique case (state_q)
         WBU_IDLE: begin
            if (in_valid) begin
               if (in_is_load) begin
                  ld_rd_d          = in_rd;
                  ld_ctx_d.wen     = in_wen;
                  ld_ctx_d.funct3  = in_funct3;
                  ld_ctx_d.addr_lo = in_addr_lo;
               end else begin
                  rf_valid_d = 1'b1;
                  rf_wen_d   = in_wen && (in_rd != '0);
                  rf_waddr_d = in_rd;
                  rf_wdata_d = in_result;
               end
            end
         end
         WBU_WAIT_LOAD: begin
            if (lsu_rvalid) begin
               if (lsu_rerr) begin
                  // faulted load: report it, write nothing, count nothing
                  load_err_d = 1'b1;
               end else begin
                  rf_valid_d = 1'b1;
                  rf_wen_d   = ld_ctx_q.wen && (ld_rd_q != '0);
                  rf_waddr_d = ld_rd_q;
                  rf_wdata_d = ext_data;
               end
            end
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------------
   // Commit and capture registers
   // ------------------------------------------------------------------------

   // Register-file strobes and the captured load context.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rf_valid_q <= 1'b0;
         rf_wen_q   <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         load_err_q <= 1'b0;
         ld_rd_q    <= '0;
         ld_ctx_q   <= '0;
      end else begin
         rf_valid_q <= rf_valid_d;
         rf_wen_q   <= rf_wen_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         load_err_q <= load_err_d;
         ld_rd_q    <= ld_rd_d;
         ld_ctx_q   <= ld_ctx_d;
      end
   end

   assign rf_valid = rf_valid_q;
   assign rf_wen   = rf_wen_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign load_err = load_err_q;

   // ------------------------------------------------------------------------
   // RAW hazard detection
   // ------------------------------------------------------------------------
   logic pend_wr;   // a load is outstanding and will write its rd
   logic land_wr;   // a register-file write lands at the end of this cycle

   assign pend_wr = (state_q == WBU_WAIT_LOAD) && ld_ctx_q.wen;
   assign land_wr = rf_valid_q && rf_wen_q;

   // Stall decode when either source register matches a write not yet
   // visible through the register file read ports; x0 never stalls.
   always_comb begin
      hz_stall = ((hz_raddr1 != '0) &&
                  ((pend_wr && (hz_raddr1 == ld_rd_q)) ||
                   (land_wr && (hz_raddr1 == rf_waddr_q)))) ||
                 ((hz_raddr2 != '0) &&
                  ((pend_wr && (hz_raddr2 == ld_rd_q)) ||
                   (land_wr && (hz_raddr2 == rf_waddr_q))));
   end

`ifdef YSYX_23060236_WBU_INSTRET_EN
   // ------------------------------------------------------------------------
   // Retired instruction counter (faulted loads never raise rf_valid)
   // ------------------------------------------------------------------------
   logic [63:0] instret_q;

   // Count one per cycle with rf_valid high; wraps naturally at 2^64.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         instret_q <= '0;
      end else if (rf_valid_q) begin
         instret_q <= instret_q + 64'd1;
      end
   end

   assign instret = instret_q;
`endif

endmodule : ysyx_23060236_wbu

// File: tb/tb_ysyx_23060236_wbu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060236_wbu
// Self-checking bench for the write-back unit. A transaction-level model
// tracks what the register-file port must show each cycle; a compare process
// checks every output on each falling edge. Directed scenarios add literal
// expectations, then a randomized phase exercises the handshake, load
// extension, bus errors, stray lsu_rvalid, hazards and random resets.
// ---------------------------------------------------------------------------
module tb_ysyx_23060236_wbu;

   localparam int AW = 4;
   localparam int DW = 32;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] in_rd = '0;
   logic          in_wen = 1'b0;
   logic          in_is_load = 1'b0;
   logic [2:0]    in_funct3 = '0;
   logic [1:0]    in_addr_lo = '0;
   logic [DW-1:0] in_result = '0;
   logic          lsu_rvalid = 1'b0;
   logic [DW-1:0] lsu_rdata = '0;
   logic          lsu_rerr = 1'b0;
   logic [DW-1:0] rf_wdata;
   logic [AW-1:0] rf_waddr;
   logic          rf_wen;
   logic          rf_valid;
   logic          load_err;
   logic [AW-1:0] hz_raddr1 = '0;
   logic [AW-1:0] hz_raddr2 = '0;
   logic          hz_stall;
`ifdef YSYX_23060236_WBU_INSTRET_EN
   logic [63:0]   instret;
`endif

   ysyx_23060236_wbu #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_rd      (in_rd),
      .in_wen     (in_wen),
      .in_is_load (in_is_load),
      .in_funct3  (in_funct3),
      .in_addr_lo (in_addr_lo),
      .in_result  (in_result),
      .lsu_rvalid (lsu_rvalid),
      .lsu_rdata  (lsu_rdata),
      .lsu_rerr   (lsu_rerr),
      .rf_wdata   (rf_wdata),
      .rf_waddr   (rf_waddr),
      .rf_wen     (rf_wen),
      .rf_valid   (rf_valid),
      .load_err   (load_err),
      .hz_raddr1  (hz_raddr1),
      .hz_raddr2  (hz_raddr2),
      .hz_stall   (hz_stall)
`ifdef YSYX_23060236_WBU_INSTRET_EN
      ,
      .instret    (instret)
`endif
   );

   always #5 clock = ~clock;

   // ------------------------------------------------------------------------
   // Bookkeeping
   // ------------------------------------------------------------------------
   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;
   bit          cmp_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: one outstanding load at most; a commit becomes visible
   // the cycle after the instruction (or its load data) is taken.
   // ------------------------------------------------------------------------
   bit          m_pending = 1'b0;
   logic [3:0]  m_prd     = '0;
   bit          m_pwen    = 1'b0;
   logic [2:0]  m_pf3     = '0;
   logic [1:0]  m_poff    = '0;
   bit          m_valid   = 1'b0;
   bit          m_wen     = 1'b0;
   bit          m_err     = 1'b0;
   logic [3:0]  m_waddr   = '0;
   logic [31:0] m_wdata   = '0;
   logic [63:0] m_instret = '0;

   // Load extension computed arithmetically from the RISC-V load rules.
   function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
      logic [31:0] b;
      logic [31:0] h;
      b = (w >> (8 * int'(off))) & 32'hFF;
      h = (w >> (16 * int'(off[1]))) & 32'hFFFF;
      case (f3)
         3'b000:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
         3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
         3'b100:  return b;
         3'b101:  return h;
         default: return w;
      endcase
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_pending <= 1'b0;
         m_prd     <= '0;
         m_pwen    <= 1'b0;
         m_pf3     <= '0;
         m_poff    <= '0;
         m_valid   <= 1'b0;
         m_wen     <= 1'b0;
         m_err     <= 1'b0;
         m_waddr   <= '0;
         m_wdata   <= '0;
         m_instret <= '0;
      end else begin
         m_instret <= m_instret + (m_valid ? 64'd1 : 64'd0);
         m_valid   <= 1'b0;
         m_wen     <= 1'b0;
         m_err     <= 1'b0;
         if (!m_pending) begin
            if (in_valid && in_is_load) begin
               m_pending <= 1'b1;
               m_prd     <= in_rd;
               m_pwen    <= in_wen;
               m_pf3     <= in_funct3;
               m_poff    <= in_addr_lo;
            end else if (in_valid) begin
               m_valid <= 1'b1;
               m_wen   <= in_wen && (in_rd != 4'd0);
               m_waddr <= in_rd;
               m_wdata <= in_result;
            end
         end else if (lsu_rvalid) begin
            m_pending <= 1'b0;
            if (lsu_rerr) begin
               m_err <= 1'b1;
            end else begin
               m_valid <= 1'b1;
               m_wen   <= m_pwen && (m_prd != 4'd0);
               m_waddr <= m_prd;
               m_wdata <= ext_model(m_pf3, m_poff, lsu_rdata);
            end
         end
      end
   end

   // A read of ra is stale if the pending load or the write now landing
   // targets it; x0 is never stale.
   function automatic bit stale(input logic [3:0] ra);
      return (ra != 4'd0) &&
             ((m_pending && m_pwen && ra == m_prd) ||
              (m_valid && m_wen && ra == m_waddr));
   endfunction

   // Compare every output against the model on each falling edge.
   always @(negedge clock) begin
      if (cmp_en) begin
         check("in_ready", in_ready, !m_pending);
         check("rf_valid", rf_valid, m_valid);
         check("rf_wen",   rf_wen,   m_wen);
         check("rf_waddr", rf_waddr, m_waddr);
         check("rf_wdata", rf_wdata, m_wdata);
         check("load_err", load_err, m_err);
         check("hz_stall", hz_stall, stale(hz_raddr1) || stale(hz_raddr2));
`ifdef YSYX_23060236_WBU_INSTRET_EN
         check("instret",  instret,  m_instret);
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers (inputs change 1 time unit after the rising edge)
   // ------------------------------------------------------------------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid   = 1'b0;
      in_is_load = 1'b0;
      in_wen     = 1'b0;
      lsu_rvalid = 1'b0;
      lsu_rerr   = 1'b0;
   endtask

   task automatic issue_alu(input logic [3:0] rd, input logic [31:0] res, input logic wen);
      in_valid   = 1'b1;
      in_is_load = 1'b0;
      in_rd      = rd;
      in_result  = res;
      in_wen     = wen;
   endtask

   task automatic issue_load(input logic [2:0] f3, input logic [1:0] off, input logic [3:0] rd);
      in_valid   = 1'b1;
      in_is_load = 1'b1;
      in_rd      = rd;
      in_wen     = 1'b1;
      in_funct3  = f3;
      in_addr_lo = off;
      in_result  = 32'hA5A5_A5A5;
   endtask

   // Full load with a hazard watcher on rs1 = rd and x0 on rs2.
   task automatic do_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] data,
                          input logic [3:0] rd, input logic [31:0] exp_data, input int wait_cyc);
      tick();
      issue_load(f3, off, rd);
      hz_raddr1 = rd;
      hz_raddr2 = 4'd0;
      tick();
      idle_inputs();
      for (int i = 0; i < wait_cyc; i++) begin
         @(negedge clock);
         check("ld_wait_ready", in_ready, 1'b0);
         check("ld_wait_stall", hz_stall, 1'b1);
         tick();
      end
      lsu_rvalid = 1'b1;
      lsu_rdata  = data;
      @(negedge clock);
      check("ld_rvalid_stall", hz_stall, 1'b1);
      tick();
      lsu_rvalid = 1'b0;
      @(negedge clock);
      check("ld_commit_valid", rf_valid, 1'b1);
      check("ld_commit_wen",   rf_wen,   1'b1);
      check("ld_commit_waddr", rf_waddr, rd);
      check("ld_commit_wdata", rf_wdata, exp_data);
      check("ld_commit_stall", hz_stall, 1'b1);
      check("ld_commit_ready", in_ready, 1'b1);
      tick();
      @(negedge clock);
      check("ld_after_stall", hz_stall, 1'b0);
      check("ld_after_valid", rf_valid, 1'b0);
   endtask

   // ------------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------------
   initial begin
      #1;
      reset  = 1'b0;
      cmp_en = 1'b1;
      repeat (2) @(negedge clock);
      check("rst_rf_valid", rf_valid, 1'b0);
      check("rst_rf_wen",   rf_wen,   1'b0);
      check("rst_rf_waddr", rf_waddr, 4'd0);
      check("rst_rf_wdata", rf_wdata, 32'd0);
      check("rst_load_err", load_err, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      tick();
      reset = 1'b1;

      // Back-to-back ALU ops.
      issue_alu(4'd5, 32'h11, 1'b1);
      tick();
      issue_alu(4'd6, 32'h22, 1'b1);
      @(negedge clock);
      check("b2b_1_valid", rf_valid, 1'b1);
      check("b2b_1_waddr", rf_waddr, 4'd5);
      check("b2b_1_wdata", rf_wdata, 32'h11);
      check("b2b_1_ready", in_ready, 1'b1);
      tick();
      idle_inputs();
      @(negedge clock);
      check("b2b_2_valid", rf_valid, 1'b1);
      check("b2b_2_waddr", rf_waddr, 4'd6);
      check("b2b_2_wdata", rf_wdata, 32'h22);
      check("b2b_2_ready", in_ready, 1'b1);
      tick();
      @(negedge clock);
      check("b2b_idle_valid", rf_valid, 1'b0);

      // Loads with extension.
      do_load(3'b000, 2'd3, 32'h80FF_0000, 4'd7, 32'hFFFF_FF80, 4);
      do_load(3'b100, 2'd3, 32'h80FF_0000, 4'd7, 32'h0000_0080, 4);
      do_load(3'b001, 2'd2, 32'h80FF_0000, 4'd7, 32'hFFFF_80FF, 2);

      // ALU op to x0.
      tick();
      issue_alu(4'd0, 32'hDEAD, 1'b1);
      hz_raddr1 = 4'd0;
      hz_raddr2 = 4'd0;
      tick();
      idle_inputs();
      @(negedge clock);
      check("x0_valid", rf_valid, 1'b1);
      check("x0_wen",   rf_wen,   1'b0);
      check("x0_wdata", rf_wdata, 32'hDEAD);
      check("x0_stall", hz_stall, 1'b0);

      // Faulted load.
      tick();
      issue_load(3'b010, 2'd0, 4'd9);
      tick();
      idle_inputs();
      repeat (2) tick();
      lsu_rvalid = 1'b1;
      lsu_rerr   = 1'b1;
      lsu_rdata  = 32'h1234_5678;
      tick();
      idle_inputs();
      @(negedge clock);
      check("err_load_err", load_err, 1'b1);
      check("err_rf_valid", rf_valid, 1'b0);
      check("err_rf_wen",   rf_wen,   1'b0);
      check("err_ready",    in_ready, 1'b1);
      check("err_wdata",    rf_wdata, 32'hDEAD);
`ifdef YSYX_23060236_WBU_INSTRET_EN
      check("err_instret",  instret,  64'd6);
`endif
      tick();
      @(negedge clock);
      check("err_pulse_end", load_err, 1'b0);
`ifdef YSYX_23060236_WBU_INSTRET_EN
      check("err_instret_hold", instret, 64'd6);
`endif

      // Reset during WAIT_LOAD, then a stray lsu_rvalid.
      tick();
      issue_load(3'b010, 2'd0, 4'd3);
      tick();
      idle_inputs();
      tick();
      reset = 1'b0;
      @(negedge clock);
      check("abort_rst_ready", in_ready, 1'b1);
      check("abort_rst_wdata", rf_wdata, 32'd0);
      tick();
      reset = 1'b1;
      tick();
      lsu_rvalid = 1'b1;
      lsu_rdata  = 32'hCAFE_F00D;
      tick();
      lsu_rvalid = 1'b0;
      @(negedge clock);
      check("abort_valid",    rf_valid, 1'b0);
      check("abort_wen",      rf_wen,   1'b0);
      check("abort_waddr",    rf_waddr, 4'd0);
      check("abort_wdata",    rf_wdata, 32'd0);
      check("abort_load_err", load_err, 1'b0);
      check("abort_ready",    in_ready, 1'b1);
`ifdef YSYX_23060236_WBU_INSTRET_EN
      check("abort_instret",  instret,  64'd0);
`endif

      // Randomized traffic; the compare process checks every cycle.
      for (int c = 0; c < 3000; c++) begin
         tick();
         reset      = ($urandom_range(0, 399) != 0);
         in_valid   = 1'($urandom_range(0, 1));
         in_is_load = ($urandom_range(0, 2) == 0);
         in_rd      = 4'($urandom_range(0, 15));
         in_wen     = ($urandom_range(0, 3) != 0);
         in_funct3  = 3'($urandom_range(0, 7));
         in_addr_lo = 2'($urandom_range(0, 3));
         in_result  = $urandom;
         lsu_rvalid = m_pending ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
         lsu_rdata  = $urandom;
         lsu_rerr   = ($urandom_range(0, 7) == 0);
         hz_raddr1  = ($urandom_range(0, 2) == 0) ? m_prd   : 4'($urandom_range(0, 15));
         hz_raddr2  = ($urandom_range(0, 2) == 0) ? m_waddr : 4'($urandom_range(0, 15));
      end

      tick();
      reset = 1'b1;
      idle_inputs();
      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_ysyx_23060236_wbu
